laundry_floor_interface: RTL and testbench
==========================================

# laundry_floor_interface

Floor-side counterpart of the laundry collection controller. It latches residents' pickup calls on four floors and drives `req_laundry[3:0]`. When the carrier reports it is at a floor, it issues `send` as the bag is loaded, then tracks each bag through washing until the resident collects it. It also owns the shared dwell/wash timer that produces `count_eq10` and `count_eq50` from the controller's `clear`.

## Interface
- `FLOOR_TIMEOUT`, default 10: dwell-cycle value that raises `count_eq10`.
- `WASH_TIME`, default 50: wash-cycle value that raises `count_eq50`.
- `CNT_W`, default 6: timer width; must hold `WASH_TIME`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `call_btn` in 4: resident pickup request, one bit per floor (bit 0 = floor 1); level or pulse.
- `bag_loaded` in 4: bag-on-carrier sensor per floor.
- `pickup` in 4: resident has collected clean laundry.
- `at_floor` in 3: carrier position from the controller. `001`..`100` = floors 1..4; `101` = idle/washing; `000` = wash done.
- `clear` in 1: timer clear from the controller.
- `wash_done` in 1: one-cycle wash-complete pulse.
- `req_laundry` out 4: floor has a pending pickup.
- `send` out 4: bag handed to the carrier at this floor.
- `return_ready` out 4: clean laundry waiting at the floor.
- `count_eq10` out 1: timer equals `FLOOR_TIMEOUT`.
- `count_eq50` out 1: timer equals `WASH_TIME`.

## Operation
- Each floor i has an independent 4-state FSM: S_IDLE, S_REQ, S_SENT, S_RET.
- **S_IDLE:** `call_btn[i]` moves the floor to S_REQ.
- **S_REQ:**
  - `req_laundry[i]` = 1.
  - When `at_floor == i+1` and `bag_loaded[i]` are both true: `send[i]` = 1 in the same cycle (combinational); next state S_SENT.
  - If the carrier leaves without a bag, the floor stays in S_REQ and waits for the next round.
- **S_SENT:** `req_laundry[i]` = 0. `wash_done` moves the floor to S_RET. `call_btn[i]` is ignored.
- **S_RET:**
  - `return_ready[i]` = 1.
  - `pickup[i]` moves the floor to S_IDLE.
  - `call_btn[i]` is ignored until S_IDLE is re-entered. A call asserted in the same cycle as `pickup` is also ignored.
- **Timer:** `CNT_W`-bit register `cnt`.
  - `clear` = 1: `cnt` ← 0 (clear has priority).
  - Otherwise: `cnt` ← `cnt + 1`, saturating at all-ones with no wrap.
  - `count_eq10 = (cnt == FLOOR_TIMEOUT)`; `count_eq50 = (cnt == WASH_TIME)`. Both are combinational from `cnt`.
- **`send` validity:**
  - At most one `send` bit can be high, since `at_floor` selects a single floor.
  - `send` is never asserted for `at_floor` values `000`, `101`, `110` or `111`.
- **`wash_done` scope:** advances every floor currently in S_SENT simultaneously.

## Timing
- **Reset values:** all floors S_IDLE, `cnt` = 0. Hence `req_laundry` = 0, `send` = 0, `return_ready` = 0, `count_eq10` = 0, `count_eq50` = 0.
- **Call latency:** call in cycle t → `req_laundry[i]` high from t+1.
- **`send` timing:** `send` is a Mealy output, valid in the cycle the floor match and bag are both present. The floor FSM leaves S_REQ at the next edge, so `send` is exactly one cycle wide even if `bag_loaded` stays high.
- **Timer timing:** `clear` high in cycle t, low from t+1 → `cnt` = k at t+1+k. `count_eq10` is high only in cycle t+1+`FLOOR_TIMEOUT`; `count_eq50` is high only in cycle t+1+`WASH_TIME`.
- **Reset mid-operation:** asynchronous return to the reset values. Pending requests and bags in flight are discarded.

## Structure
- **Shared package:**
  - Floor-FSM state encodings.
  - `at_floor` codes: `AT_F1`..`AT_F4` = 1..4, `AT_IDLE` = 5, `AT_DONE` = 0.
  - `FLOOR_TIMEOUT`/`WASH_TIME` defaults.
- **Sub-module:** `laundry_floor_station` (one floor FSM with `FLOOR_ID` parameter), instantiated 4×. Timer and output packing stay in the top module.

## Test plan
- **Reset:** deassert `reset` with all inputs 0 → every output 0; `cnt` counts; `count_eq10` pulses once, 11 cycles after the last `clear`.
- **Normal pickup:** `call_btn` = 0100 → `req_laundry` = 0100. Then `at_floor` = 011 with `bag_loaded[2]` = 1 → `send` = 0100 for one cycle, `req_laundry` = 0000.
- **Missed pickup:** `call_btn` = 0010, `at_floor` = 010 with no bag, then `at_floor` moves to 001 → `send` = 0; `req_laundry[1]` stays 1.
- **Return path:** floors 1 and 4 in S_SENT, `wash_done` pulse → `return_ready` = 1001. `pickup` = 0001 → `return_ready` = 1000.
- **Wash timer:** `clear` 1→0 → `count_eq50` high exactly 51 cycles later for one cycle. Holding `clear` high keeps both count flags 0.
- **Asynchronous reset mid-wash:** assert `reset` low mid-wash → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/laundry_floor_interface_pkg.sv
// Shared definitions for the laundry floor interface: floor FSM encodings,
// carrier position codes and timer defaults.
package laundry_floor_interface_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SENT = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  localparam logic [2:0] AT_DONE = 3'd0;
  localparam logic [2:0] AT_F1   = 3'd1;
  localparam logic [2:0] AT_F2   = 3'd2;
  localparam logic [2:0] AT_F3   = 3'd3;
  localparam logic [2:0] AT_F4   = 3'd4;
  localparam logic [2:0] AT_IDLE = 3'd5;

  localparam int FLOOR_TIMEOUT_DEF = 10;
  localparam int WASH_TIME_DEF     = 50;
  localparam int CNT_W_DEF         = 6;

  // Floor index 0..3 maps onto the carrier position code AT_F1..AT_F4.
  function automatic logic [2:0] floor_code(input int idx);
    return 3'(idx + 1);
  endfunction

endpackage

// File: rtl/laundry_floor_station.sv
// One floor's pickup/return FSM: call -> bag handed over -> washing -> collected.
module laundry_floor_station
  import laundry_floor_interface_pkg::*;
#(
  parameter logic [2:0] FLOOR_ID = AT_F1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_btn,
  input  logic       bag_loaded,
  input  logic       pickup,
  input  logic [2:0] at_floor,
  input  logic       wash_done,
  output logic       req_laundry,
  output logic       send,
  output logic       return_ready
);

  logic [1:0] state_reg, state_next;

  // FLOOR_ID is always 1..4, so idle/done/unused position codes never match.
  assign send         = (state_reg == S_REQ) && (at_floor == FLOOR_ID) && bag_loaded;
  assign req_laundry  = (state_reg == S_REQ);
  assign return_ready = (state_reg == S_RET);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (call_btn)  state_next = S_REQ;
      S_REQ:   if (send)      state_next = S_SENT;
      S_SENT:  if (wash_done) state_next = S_RET;
      S_RET:   if (pickup)    state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

endmodule

// File: rtl/laundry_floor_interface.sv
// Floor-side interface for the laundry collection controller: four floor
// stations plus the shared dwell/wash timer.
module laundry_floor_interface
  import laundry_floor_interface_pkg::*;
#(
  parameter int FLOOR_TIMEOUT = FLOOR_TIMEOUT_DEF,
  parameter int WASH_TIME     = WASH_TIME_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [3:0] bag_loaded,
  input  logic [3:0] pickup,
  input  logic [2:0] at_floor,
  input  logic       clear,
  input  logic       wash_done,
  output logic [3:0] req_laundry,
  output logic [3:0] send,
  output logic [3:0] return_ready,
  output logic       count_eq10,
  output logic       count_eq50
);

  logic [CNT_W-1:0] cnt_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_floor
    laundry_floor_station #(
      .FLOOR_ID(floor_code(gi))
    ) u_station (
      .clk         (clk),
      .reset       (reset),
      .call_btn    (call_btn[gi]),
      .bag_loaded  (bag_loaded[gi]),
      .pickup      (pickup[gi]),
      .at_floor    (at_floor),
      .wash_done   (wash_done),
      .req_laundry (req_laundry[gi]),
      .send        (send[gi]),
      .return_ready(return_ready[gi])
    );
  end

  // Saturates at all-ones so a long idle period cannot wrap into a false match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt_reg <= '0;
    else if (clear)              cnt_reg <= '0;
    else if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
  end

  assign count_eq10 = (cnt_reg == CNT_W'(FLOOR_TIMEOUT));
  assign count_eq50 = (cnt_reg == CNT_W'(WASH_TIME));

endmodule

// File: tb/tb_laundry_floor_interface.sv
// Randomized self-checking bench for laundry_floor_interface against a
// behavioural model of floor bookkeeping and elapsed-time-since-clear.
module tb_laundry_floor_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_btn, bag_loaded, pickup;
  logic [2:0] at_floor;
  logic       clear, wash_done;
  logic [3:0] req_laundry, send, return_ready;
  logic       count_eq10, count_eq50;

  int errors = 0;
  int checks = 0;

  // Model: per-floor sets of pending calls, bags in the wash, clean bags waiting,
  // and elapsed cycles since the last clear (saturating at the 6-bit maximum).
  logic [3:0] m_pending, m_washing, m_ready;
  int         m_elapsed;

  laundry_floor_interface dut (
    .clk         (clk),
    .reset       (reset),
    .call_btn    (call_btn),
    .bag_loaded  (bag_loaded),
    .pickup      (pickup),
    .at_floor    (at_floor),
    .clear       (clear),
    .wash_done   (wash_done),
    .req_laundry (req_laundry),
    .send        (send),
    .return_ready(return_ready),
    .count_eq10  (count_eq10),
    .count_eq50  (count_eq50)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_washing = '0;
    m_ready   = '0;
    m_elapsed = 0;
  endtask

  function automatic logic [3:0] exp_send();
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      if (m_pending[i] && bag_loaded[i] && (int'(at_floor) == i + 1)) s[i] = 1'b1;
    return s;
  endfunction

  task automatic check_all(input string ctx);
    check_eq({ctx, ":req_laundry"},  32'(req_laundry),  32'(m_pending));
    check_eq({ctx, ":send"},         32'(send),         32'(exp_send()));
    check_eq({ctx, ":return_ready"}, 32'(return_ready), 32'(m_ready));
    check_eq({ctx, ":count_eq10"},   32'(count_eq10),   32'(m_elapsed == 10));
    check_eq({ctx, ":count_eq50"},   32'(count_eq50),   32'(m_elapsed == 50));
  endtask

  // One clock cycle: inputs already applied, check mid-cycle, then advance model.
  task automatic step(input string ctx);
    logic [3:0] snd, np, nw, nr;
    @(negedge clk);
    check_all(ctx);
    $display("cyc %s call=%b bag=%b at=%0d wd=%b pk=%b clr=%b -> req=%b send=%b ret=%b eq10=%b eq50=%b",
             ctx, call_btn, bag_loaded, at_floor, wash_done, pickup, clear,
             req_laundry, send, return_ready, count_eq10, count_eq50);
    snd = exp_send();
    np = m_pending; nw = m_washing; nr = m_ready;
    for (int i = 0; i < 4; i++) begin
      if (!m_pending[i] && !m_washing[i] && !m_ready[i] && call_btn[i]) np[i] = 1'b1;
      if (snd[i]) begin np[i] = 1'b0; nw[i] = 1'b1; end
      if (m_washing[i] && wash_done) begin nw[i] = 1'b0; nr[i] = 1'b1; end
      if (m_ready[i] && pickup[i]) nr[i] = 1'b0;
    end
    m_pending = np; m_washing = nw; m_ready = nr;
    m_elapsed = clear ? 0 : ((m_elapsed + 1 > 63) ? 63 : m_elapsed + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    call_btn = '0; bag_loaded = '0; pickup = '0;
    at_floor = 3'd5; clear = 1'b0; wash_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    at_floor = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    reset = 1'b1;

    // Free-running timer after reset: count_eq10 pulse falls out of the model.
    for (int k = 0; k < 14; k++) step("post_reset");

    // Normal pickup on floor 3.
    clear = 1'b1; step("clr");
    clear = 1'b0;
    call_btn = 4'b0100; step("call3");
    call_btn = 4'b0000; step("req3");
    check_eq("req3_direct", 32'(req_laundry), 32'h4);
    at_floor = 3'd3; bag_loaded = 4'b0100;
    @(negedge clk);
    check_eq("send3_direct", 32'(send), 32'h4);
    @(posedge clk); #1;
    // replay that cycle through the model without a second clock edge
    m_pending[2] = 1'b0; m_washing[2] = 1'b1;
    m_elapsed = m_elapsed + 1;
    step("bag_held");
    check_eq("send3_one_cycle", 32'(send), 32'h0);
    idle_inputs();

    // Missed pickup on floor 2: carrier passes without a bag.
    call_btn = 4'b0010; step("call2");
    call_btn = '0; at_floor = 3'd2; step("miss2");
    at_floor = 3'd1; step("leave2");
    check_eq("req2_kept", 32'(req_laundry[1]), 32'h1);

    // Return path with floors 1 and 4 both in the wash.
    call_btn = 4'b1001; at_floor = 3'd5; step("call14");
    call_btn = '0; at_floor = 3'd1; bag_loaded = 4'b0001; step("load1");
    at_floor = 3'd4; bag_loaded = 4'b1000; step("load4");
    bag_loaded = '0; at_floor = 3'd5; wash_done = 1'b1; step("wash_done");
    wash_done = 1'b0; step("ready");
    check_eq("ret_1001", 32'(return_ready & 4'b1001), 32'h9);
    pickup = 4'b0001; call_btn = 4'b0001; step("pick1");
    pickup = '0; call_btn = '0; step("after_pick");
    check_eq("ret_1000", 32'(return_ready & 4'b1001), 32'h8);

    // Wash timer: clear held, then released for a long run including saturation.
    clear = 1'b1;
    for (int k = 0; k < 5; k++) step("clr_hold");
    clear = 1'b0;
    for (int k = 0; k < 70; k++) step("wash_timer");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      call_btn   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bag_loaded = 4'($urandom);
      pickup     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      at_floor   = 3'($urandom_range(0, 7));
      wash_done  = ($urandom_range(0, 9) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    // Asynchronous reset mid-wash: outputs drop without a clock edge.
    idle_inputs();
    call_btn = 4'b1111; step("pre_rst_call");
    call_btn = '0; at_floor = 3'd2; bag_loaded = 4'b0010; step("pre_rst_load");
    at_floor = 3'd5; bag_loaded = '0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("async_req",    32'(req_laundry),  32'h0);
    check_eq("async_send",   32'(send),         32'h0);
    check_eq("async_ret",    32'(return_ready), 32'h0);
    check_eq("async_eq10",   32'(count_eq10),   32'h0);
    check_eq("async_eq50",   32'(count_eq50),   32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 15; k++) step("after_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
